// File: rtl/nco_pkg.sv
// Shared constants, state encodings and the shift/saturate helper for the NCO mixer/integrator.
package nco_pkg;
    localparam int NCO_W = 18;
    localparam int NCH   = 4;
    localparam int NSTEP = 2 * NCH;

    typedef enum logic [1:0] {MAC_IDLE, MAC_RUN, MAC_FLUSH} mac_state_t;
    typedef enum logic {OUT_EMPTY, OUT_SEND} out_state_t;

    // Step k multiplies by term k: even k = cos, odd k = sin, of channel k/2
    typedef logic [2:0] mac_step_t;
    localparam mac_step_t STEP_LAST = mac_step_t'(NSTEP - 1);

    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int shift, input int out_w);
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        sh = acc >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (sh > hi)
            res = hi;
        else if (sh < lo)
            res = lo;
        else
            res = sh;
        return res;
    endfunction
endpackage

// File: rtl/nco_iq_out_fifo4.sv
// Holds one frame's 8 integrated values and streams them as 4 (I,Q) beats under valid/ready.
//   state     | meaning
//   OUT_EMPTY | no snapshot held; a frame end loads one
//   OUT_SEND  | beat out_ch presented; advances on out_valid & out_ready
module nco_iq_out_fifo4 #(
    parameter int ACC_W     = 44,
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 20
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic                    load,
    input  logic signed [ACC_W-1:0] acc_i [nco_pkg::NCH],
    input  logic signed [ACC_W-1:0] acc_q [nco_pkg::NCH],
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [1:0]              out_ch,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    frame_drop
);
    import nco_pkg::*;

    out_state_t              state;
    logic signed [ACC_W-1:0] snap_i [NCH];
    logic signed [ACC_W-1:0] snap_q [NCH];
    logic [1:0]              ch_next;

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        return OUT_W'(sat_shift(64'(a), OUT_SHIFT, OUT_W));
    endfunction

    assign ch_next = out_ch + 2'd1;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state      <= OUT_EMPTY;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_i      <= '0;
            out_q      <= '0;
            frame_drop <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                snap_i[k] <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            case (state)
                OUT_EMPTY: begin
                    if (load) begin
                        for (int k = 0; k < NCH; k++) begin
                            snap_i[k] <= acc_i[k];
                            snap_q[k] <= acc_q[k];
                        end
                        out_ch    <= '0;
                        out_i     <= sat_out(acc_i[0]);
                        out_q     <= sat_out(acc_q[0]);
                        out_valid <= 1'b1;
                        state     <= OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    // A frame ending while the snapshot is still draining is lost, not queued
                    if (load)
                        frame_drop <= 1'b1;
                    if (out_ready) begin
                        if (out_ch == 2'(NCH - 1)) begin
                            state     <= OUT_EMPTY;
                            out_valid <= 1'b0;
                            out_ch    <= '0;
                            out_i     <= '0;
                            out_q     <= '0;
                        end else begin
                            out_ch <= ch_next;
                            out_i  <= sat_out(snap_i[ch_next]);
                            out_q  <= sat_out(snap_q[ch_next]);
                        end
                    end
                end
                default: state <= OUT_EMPTY;
            endcase
        end
    end
endmodule

// File: rtl/nco_mix_accum_4ch.sv
// Mixes each audio sample with four NCO phasors through one shared multiplier and integrates per frame.
//   state     | meaning
//   MAC_IDLE  | waiting for sample_valid
//   MAC_RUN   | step k: prod <= x*term[k], acc[k-1] += previous prod
//   MAC_FLUSH | acc[7] += last prod, advance sample count, frame end on wrap
module nco_mix_accum_4ch #(
    parameter int SAMPLE_W  = 16,
    parameter int NCO_W     = nco_pkg::NCO_W,
    parameter int FRAME_LEN = 1024,
    parameter int ACC_W     = SAMPLE_W + NCO_W + $clog2(FRAME_LEN),
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 20
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [NCO_W-1:0]    cos0,
    input  logic signed [NCO_W-1:0]    cos1,
    input  logic signed [NCO_W-1:0]    cos2,
    input  logic signed [NCO_W-1:0]    cos3,
    input  logic signed [NCO_W-1:0]    sin0,
    input  logic signed [NCO_W-1:0]    sin1,
    input  logic signed [NCO_W-1:0]    sin2,
    input  logic signed [NCO_W-1:0]    sin3,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_ch,
    output logic signed [OUT_W-1:0]    out_i,
    output logic signed [OUT_W-1:0]    out_q,
    output logic                       overrun,
    output logic                       frame_drop
);
    import nco_pkg::*;

    localparam int PROD_W = SAMPLE_W + NCO_W;
    localparam int CNT_W  = $clog2(FRAME_LEN);

    mac_state_t                 state;
    mac_step_t                  step;
    logic signed [SAMPLE_W-1:0] x_reg;
    logic signed [NCO_W-1:0]    term [NSTEP];
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc [NSTEP];
    logic [CNT_W-1:0]           cnt;

    logic signed [PROD_W-1:0]   prod_next;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_fin_i [NCH];
    logic signed [ACC_W-1:0]    acc_fin_q [NCH];
    logic                       frame_end;

    // The only multiplier in the block
    assign prod_next = x_reg * term[step];
    assign prod_ext  = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign frame_end = (state == MAC_FLUSH) && (cnt == CNT_W'(FRAME_LEN - 1));

    // Snapshot view: the last sin accumulator already includes the product being flushed
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            acc_fin_i[ch] = acc[2*ch];
            acc_fin_q[ch] = acc[2*ch + 1];
        end
        acc_fin_q[NCH-1] = acc[NSTEP-1] + prod_ext;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state   <= MAC_IDLE;
            step    <= '0;
            x_reg   <= '0;
            prod    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            for (int k = 0; k < NSTEP; k++) begin
                term[k] <= '0;
                acc[k]  <= '0;
            end
        end else begin
            case (state)
                MAC_IDLE: begin
                    if (sample_valid) begin
                        x_reg   <= sample;
                        term[0] <= cos0;
                        term[1] <= sin0;
                        term[2] <= cos1;
                        term[3] <= sin1;
                        term[4] <= cos2;
                        term[5] <= sin2;
                        term[6] <= cos3;
                        term[7] <= sin3;
                        step    <= '0;
                        busy    <= 1'b1;
                        state   <= MAC_RUN;
                    end
                end
                MAC_RUN: begin
                    prod <= prod_next;
                    if (step != '0)
                        acc[step - 3'd1] <= acc[step - 3'd1] + prod_ext;
                    if (step == STEP_LAST)
                        state <= MAC_FLUSH;
                    step <= step + 3'd1;
                end
                MAC_FLUSH: begin
                    cnt   <= cnt + CNT_W'(1);
                    busy  <= 1'b0;
                    state <= MAC_IDLE;
                    if (frame_end) begin
                        for (int k = 0; k < NSTEP; k++)
                            acc[k] <= '0;
                    end else begin
                        acc[NSTEP-1] <= acc[NSTEP-1] + prod_ext;
                    end
                end
                default: state <= MAC_IDLE;
            endcase
            if (sample_valid && state != MAC_IDLE)
                overrun <= 1'b1;
        end
    end

    nco_iq_out_fifo4 #(
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_out (
        .ck         (ck),
        .rst        (rst),
        .load       (frame_end),
        .acc_i      (acc_fin_i),
        .acc_q      (acc_fin_q),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_i      (out_i),
        .out_q      (out_q),
        .frame_drop (frame_drop)
    );
endmodule

// File: tb/tb_nco_mix_accum_4ch.sv
// Bench for nco_mix_accum_4ch: a 40-bit and a 24-bit output instance share stimulus, FRAME_LEN=4, no shift.
module tb_nco_mix_accum_4ch;
    logic               ck = 1'b0;
    logic               rst;
    logic               sample_valid;
    logic signed [15:0] sample;
    logic signed [17:0] cos_v [4];
    logic signed [17:0] sin_v [4];
    logic               out_ready;

    logic               busy_w, ovalid_w, ov_w, fd_w;
    logic [1:0]         och_w;
    logic signed [39:0] oi_w, oq_w;
    logic               busy_n, ovalid_n, ov_n, fd_n;
    logic [1:0]         och_n;
    logic signed [23:0] oi_n, oq_n;

    always #5 ck = ~ck;

    nco_mix_accum_4ch #(.FRAME_LEN(4), .OUT_W(40), .OUT_SHIFT(0)) dut_w (
        .ck(ck), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .cos0(cos_v[0]), .cos1(cos_v[1]), .cos2(cos_v[2]), .cos3(cos_v[3]),
        .sin0(sin_v[0]), .sin1(sin_v[1]), .sin2(sin_v[2]), .sin3(sin_v[3]),
        .busy(busy_w), .out_valid(ovalid_w), .out_ready(out_ready), .out_ch(och_w),
        .out_i(oi_w), .out_q(oq_w), .overrun(ov_w), .frame_drop(fd_w));

    nco_mix_accum_4ch #(.FRAME_LEN(4), .OUT_W(24), .OUT_SHIFT(0)) dut_n (
        .ck(ck), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .cos0(cos_v[0]), .cos1(cos_v[1]), .cos2(cos_v[2]), .cos3(cos_v[3]),
        .sin0(sin_v[0]), .sin1(sin_v[1]), .sin2(sin_v[2]), .sin3(sin_v[3]),
        .busy(busy_n), .out_valid(ovalid_n), .out_ready(out_ready), .out_ch(och_n),
        .out_i(oi_n), .out_q(oq_n), .overrun(ov_n), .frame_drop(fd_n));

    typedef struct { int ch; longint i; longint q; } beat_t;
    beat_t q_w[$];
    beat_t q_n[$];

    // One row per (vector, channel); the same x is applied for all 4 samples of the frame
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [17:0] c;
        logic signed [17:0] s;
        logic signed [39:0] ei;
        logic signed [39:0] eq;
    } row_t;
    row_t tbl [16];

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_ready = 1'b0;

    always @(negedge ck) begin
        if (!rst && out_ready) begin
            if (ovalid_w) q_w.push_back(beat_t'{int'(och_w), longint'(oi_w), longint'(oq_w)});
            if (ovalid_n) q_n.push_back(beat_t'{int'(och_n), longint'(oi_n), longint'(oq_n)});
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat24(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ck);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_sample(input logic signed [15:0] x, input logic signed [17:0] c [4],
                               input logic signed [17:0] s [4]);
        sample = x;
        for (int k = 0; k < 4; k++) begin
            cos_v[k] = c[k];
            sin_v[k] = s[k];
        end
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick(9);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        out_ready = 1'b1;
        rand_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick();
        q_w.delete();
        q_n.delete();
    endtask

    task automatic check_frame(input string tag, input longint ei [4], input longint eq [4]);
        beat_t b;
        int guard = 0;
        while ((q_w.size() < 4 || q_n.size() < 4) && guard < 400) begin
            tick();
            guard++;
        end
        if (q_w.size() < 4 || q_n.size() < 4) begin
            check({tag, "_beat_timeout"}, longint'(q_w.size() + q_n.size()), 8);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            b = q_w.pop_front();
            check($sformatf("%s_w_ch%0d", tag, k), b.ch, k);
            check($sformatf("%s_w_i%0d", tag, k), b.i, ei[k]);
            check($sformatf("%s_w_q%0d", tag, k), b.q, eq[k]);
            b = q_n.pop_front();
            check($sformatf("%s_n_ch%0d", tag, k), b.ch, k);
            check($sformatf("%s_n_i%0d", tag, k), b.i, sat24(ei[k]));
            check($sformatf("%s_n_q%0d", tag, k), b.q, sat24(eq[k]));
        end
    endtask

    task automatic send_row_frame(input int v);
        logic signed [17:0] c [4];
        logic signed [17:0] s [4];
        for (int k = 0; k < 4; k++) begin
            c[k] = tbl[v*4 + k].c;
            s[k] = tbl[v*4 + k].s;
        end
        repeat (4) send_sample(tbl[v*4].x, c, s);
    endtask

    task automatic run_vector(input int v, input string tag);
        longint ei [4];
        longint eq [4];
        send_row_frame(v);
        for (int k = 0; k < 4; k++) begin
            ei[k] = longint'($signed(tbl[v*4 + k].ei));
            eq[k] = longint'($signed(tbl[v*4 + k].eq));
        end
        check_frame(tag, ei, eq);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [17:0] c [4];
        logic signed [17:0] s [4];
        longint ei [4];
        longint eq [4];
        longint exp_i [3][4];
        longint exp_q [3][4];
        logic signed [15:0] x;

        // x, cos, sin, expected I, expected Q (40-bit instance; the 24-bit one saturates these)
        for (int k = 0; k < 4; k++) begin
            tbl[k]     = '{16'sd1000, 18'sd131071, 18'sd0, 40'sd524284000, 40'sd0};
            tbl[4 + k] = '{16'h8000, 18'h20000, 18'sd0, 40'sd17179869184, 40'sd0};
        end
        tbl[8]  = '{16'sd3, 18'sd1, 18'sd5, 40'sd12, 40'sd60};
        tbl[9]  = '{16'sd3, -18'sd2, 18'sd6, -40'sd24, 40'sd72};
        tbl[10] = '{16'sd3, 18'sd3, -18'sd7, 40'sd36, -40'sd84};
        tbl[11] = '{16'sd3, -18'sd4, 18'sd8, -40'sd48, 40'sd96};
        tbl[12] = '{16'h8000, 18'sd0, 18'h20000, 40'sd0, 40'sd17179869184};
        tbl[13] = '{16'h8000, 18'sd131071, 18'sd0, -40'sd17179738112, 40'sd0};
        tbl[14] = '{16'h8000, -18'sd1, 18'sd1, 40'sd131072, -40'sd131072};
        tbl[15] = '{16'h8000, 18'sd2, 18'sd0, -40'sd262144, 40'sd0};

        rst = 1'b1;
        sample_valid = 1'b0;
        sample = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cos_v[k] = '0;
            sin_v[k] = '0;
        end

        // Reset mid-MAC while a beat is pending and OVERRUN is set
        do_reset();
        out_ready = 1'b0;
        send_row_frame(0);
        check("t1_valid_pending", longint'(ovalid_w), 1);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick(2);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        check("t1_busy_mid", longint'(busy_w), 1);
        check("t1_overrun_set", longint'(ov_w), 1);
        #2 rst = 1'b1;
        #1;
        check("t1_rst_valid", longint'(ovalid_w), 0);
        check("t1_rst_ch", longint'(och_w), 0);
        check("t1_rst_i", longint'(oi_w), 0);
        check("t1_rst_q", longint'(oq_w), 0);
        check("t1_rst_busy", longint'(busy_w), 0);
        check("t1_rst_overrun", longint'(ov_w), 0);
        check("t1_rst_drop", longint'(fd_w), 0);
        check("t1_rst_valid_n", longint'(ovalid_n), 0);
        check("t1_rst_i_n", longint'(oi_n), 0);
        tick();
        rst = 1'b0;
        tick();
        q_w.delete();
        q_n.delete();
        out_ready = 1'b1;
        run_vector(2, "t1_after");

        // Table vectors: DC, saturation, per-channel signs
        for (int v = 0; v < 4; v++) begin
            do_reset();
            run_vector(v, $sformatf("vec%0d", v));
            tick(5);
            check($sformatf("vec%0d_no_extra", v), longint'(q_w.size()), 0);
        end

        // Timing: BUSY t+1..t+9, sample at t+5 ignored, sample at t+10 accepted
        do_reset();
        for (int k = 0; k < 4; k++) begin
            c[k] = 18'sd1;
            s[k] = 18'sd2;
            cos_v[k] = c[k];
            sin_v[k] = s[k];
        end
        sample = 16'sd1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            check($sformatf("t3_busy_t%0d", cyc), longint'(busy_w), (cyc <= 9) ? 1 : 0);
            if (cyc == 5) begin
                sample = 16'sd100;
                sample_valid = 1'b1;
            end
            if (cyc == 10) begin
                sample = 16'sd2;
                sample_valid = 1'b1;
            end
            tick();
            sample_valid = 1'b0;
        end
        check("t3_overrun", longint'(ov_w), 1);
        check("t3_busy_t11", longint'(busy_w), 1);
        tick(9);
        send_sample(16'sd0, c, s);
        send_sample(16'sd0, c, s);
        for (int k = 0; k < 4; k++) begin
            ei[k] = 3;
            eq[k] = 6;
        end
        check_frame("t3", ei, eq);

        // Backpressure across two frame ends
        do_reset();
        out_ready = 1'b0;
        send_row_frame(2);
        send_row_frame(0);
        check("t5_drop_w", longint'(fd_w), 1);
        check("t5_drop_n", longint'(fd_n), 1);
        check("t5_valid_held", longint'(ovalid_w), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5_valid%0d", k), longint'(ovalid_w), 1);
            check($sformatf("t5_ch%0d", k), longint'(och_w), k);
            check($sformatf("t5_i%0d", k), longint'(oi_w), longint'($signed(tbl[8 + k].ei)));
            check($sformatf("t5_q%0d", k), longint'(oq_w), longint'($signed(tbl[8 + k].eq)));
            tick();
        end
        check("t5_drained", longint'(ovalid_w), 0);
        q_w.delete();
        q_n.delete();
        run_vector(3, "t5_after_drop");

        // Random frames with random OUT_READY against a running-sum model
        do_reset();
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                exp_i[f][k] = 0;
                exp_q[f][k] = 0;
            end
            for (int n = 0; n < 4; n++) begin
                x = 16'($urandom);
                for (int k = 0; k < 4; k++) begin
                    c[k] = 18'($urandom);
                    s[k] = 18'($urandom);
                    exp_i[f][k] += longint'(x) * longint'(c[k]);
                    exp_q[f][k] += longint'(x) * longint'(s[k]);
                end
                send_sample(x, c, s);
            end
        end
        tick(2);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                ei[k] = exp_i[f][k];
                eq[k] = exp_q[f][k];
            end
            check_frame($sformatf("rnd%0d", f), ei, eq);
        end
        tick(5);
        check("rnd_no_extra", longint'(q_w.size() + q_n.size()), 0);
        check("rnd_no_drop", longint'(fd_w), 0);
        check("rnd_no_overrun", longint'(ov_w), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
